fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised instruction-fetch unit. Owns the fetch PC and issues word requests to instruction memory over a valid/ready request channel with a single response channel.
- Buffers returned instructions, with their PCs, in a DEPTH-entry FIFO that feeds decode through a valid/ready handshake.
- Replaces stall-driven fetch with back-pressure.
- Supports redirect (branch/exception) with queue flush and squashing of an in-flight response.

Parameters:
XLEN, 32, width of PC, addresses and instruction word
RESET_PC, 32'h0000_0000, fetch PC after reset (XLEN bits, bits [1:0] zero)
DEPTH, 4, instruction queue entries; power of two, >= 2

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset
redirect_valid  in  1  redirect fetch to redirect_pc this cycle
redirect_pc  in  XLEN  redirect target
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  word-aligned fetch address
imem_rsp_valid  in  1  instruction data returned (one per accepted request, in order, >=1 cycle after acceptance)
imem_rsp_data  in  XLEN  instruction word
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_pc  out  XLEN  PC of head instruction
out_inst  out  XLEN  head instruction
out_next_pc  out  XLEN  out_pc + 4 (mod 2^XLEN)

Behaviour:
- Reset: rst_n synchronous, active-low; clock clk. On reset:
  - fetch_pc = RESET_PC; queue empty (count 0, pointers 0)
  - outstanding = 0; drop = 0
  - outputs: imem_req_valid = 0, out_valid = 0, out_pc/out_inst/out_next_pc = 0 while empty
  - Reset mid-transaction discards the in-flight response; memory must tolerate this.
- Internal state:
  - fetch_pc
  - req_pc: address of the outstanding request
  - outstanding: at most one request in flight
  - drop: squash flag for the outstanding request
  - FIFO of {pc, inst}, count 0..DEPTH
- imem_req_addr = {fetch_pc[XLEN-1:2], 2'b00}.
- imem_req_valid = !redirect_valid && (!outstanding || imem_rsp_valid) && space, where space = (count + outstanding) < DEPTH.
  - space uses the registered count; a same-cycle pop does not free space.
  - Yields 1 instruction/cycle with a 1-cycle memory.
- Request accepted (valid && ready):
  - req_pc <= fetch_pc; fetch_pc <= fetch_pc + 4 (wraps); outstanding stays/becomes 1.
  - imem_req_valid may drop without acceptance; fetch_pc holds.
- Response with outstanding = 1:
  - drop = 0: push {req_pc, imem_rsp_data}.
  - drop = 1: discard, clear drop.
  - Either way outstanding clears unless a new request is accepted the same cycle.
- Response with outstanding = 0: ignored (protocol error, no state change).
- Output:
  - out_valid = (count != 0); head fields driven combinationally from the FIFO head.
  - Pop on out_valid && out_ready. Head stays stable while out_ready = 0.
  - Push and pop in the same cycle: count unchanged.
- Redirect (highest priority):
  - FIFO cleared (count 0, pointers 0); a same-cycle pop or push is ignored.
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - If outstanding and no response this cycle: drop <= 1.
  - If a response arrives this cycle: it is discarded, outstanding <= 0, drop <= 0.
  - No request issued in the redirect cycle; fetch resumes next cycle.
  - Back-to-back redirects: last one wins.
- Full: count == DEPTH gives no requests. With outstanding = 1, requests stop at count == DEPTH-1, so a pending response always has a slot. No overflow possible.
- Empty: out_valid = 0; out_ready ignored.

Test Plan:
- Reset with RESET_PC = 0x100, imem_req_ready = 1, 1-cycle memory, out_ready = 1 → after rst_n rises, addresses 0x100, 0x104, 0x108 are issued on consecutive cycles. out_pc sequence is 0x100, 0x104, … with out_next_pc = out_pc + 4, one per cycle.
- Back-pressure: out_ready = 0 for 10 cycles, DEPTH = 4 → exactly 4 entries queued (0x100..0x10C). imem_req_valid = 0 while full, head stable at 0x100. Releasing out_ready drains in order with no loss or duplicate.
- Redirect with in-flight request: request 0x108 accepted, redirect_pc = 0x2002 asserted before its response → response discarded, queue empty. Next request address is 0x2000; next out_pc is 0x2000.
- Redirect coincident with response and pop: redirect_pc = 0x3000 on the same cycle as imem_rsp_valid and out_ready → nothing pushed, count 0. Following request 0x3000, no stale instruction emerges.
- Memory stall: imem_req_ready = 0 for 5 cycles → imem_req_addr held, fetch_pc unchanged. Variable response latency of 1–4 cycles keeps order and PC/inst pairing intact.
- Wrap: redirect_pc = 0xFFFF_FFFC → requests 0xFFFF_FFFC then 0x0000_0000; out_next_pc of the first is 0x0000_0000.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction-fetch unit: owns the fetch PC, keeps at most one memory request in
// flight, and buffers returned {pc, inst} pairs in a small FIFO feeding decode.
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_next_pc
);

  localparam int unsigned     PTRW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CNTW    = PTRW + 1;
  localparam logic [CNTW:0]   DEPTH_C = (CNTW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] WORD    = XLEN'(4);

  logic [XLEN-1:0] fetchPc_q, fetchPc_d;
  logic [XLEN-1:0] reqPc_q, reqPc_d;
  logic            outstanding_q, outstanding_d;
  logic            drop_q, drop_d;
  logic [PTRW-1:0] wrPtr_q, wrPtr_d;
  logic [PTRW-1:0] rdPtr_q, rdPtr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [XLEN-1:0] pcMem_q   [DEPTH];
  logic [XLEN-1:0] instMem_q [DEPTH];

  logic space;
  logic reqFire;
  logic rspFire;
  logic push;
  logic pop;

  // Space counts the in-flight request so a pending response always has a slot.
  assign space   = ({1'b0, count_q} + {{CNTW{1'b0}}, outstanding_q}) < DEPTH_C;
  assign imem_req_valid = rst_n && !redirect_valid
                       && (!outstanding_q || imem_rsp_valid) && space;
  assign imem_req_addr  = {fetchPc_q[XLEN-1:2], 2'b00};

  assign reqFire = imem_req_valid && imem_req_ready;
  assign rspFire = outstanding_q && imem_rsp_valid;
  assign push    = rspFire && !drop_q && !redirect_valid;
  assign out_valid = (count_q != '0);
  assign pop     = out_valid && out_ready && !redirect_valid;

  assign out_pc      = out_valid ? pcMem_q[rdPtr_q]   : '0;
  assign out_inst    = out_valid ? instMem_q[rdPtr_q] : '0;
  assign out_next_pc = out_valid ? (pcMem_q[rdPtr_q] + WORD) : '0;

  always_comb begin
    fetchPc_d     = fetchPc_q;
    reqPc_d       = reqPc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    wrPtr_d       = wrPtr_q;
    rdPtr_d       = rdPtr_q;
    count_d       = count_q;

    // A redirect flushes the queue and squashes whatever response is still owed.
    if (redirect_valid) begin
      fetchPc_d = {redirect_pc[XLEN-1:2], 2'b00};
      wrPtr_d   = '0;
      rdPtr_d   = '0;
      count_d   = '0;
      if (rspFire) begin
        outstanding_d = 1'b0;
        drop_d        = 1'b0;
      end else if (outstanding_q) begin
        drop_d = 1'b1;
      end
    end else begin
      if (reqFire) begin
        reqPc_d   = fetchPc_q;
        fetchPc_d = fetchPc_q + WORD;
      end
      if (rspFire) begin
        drop_d = 1'b0;
      end
      if (reqFire) begin
        outstanding_d = 1'b1;
      end else if (rspFire) begin
        outstanding_d = 1'b0;
      end
      if (push) begin
        wrPtr_d = wrPtr_q + PTRW'(1);
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + PTRW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNTW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetchPc_q     <= RESET_PC;
      reqPc_q       <= '0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      count_q       <= '0;
    end else begin
      fetchPc_q     <= fetchPc_d;
      reqPc_q       <= reqPc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      count_q       <= count_d;
    end
  end

  // Storage needs no reset; the outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pcMem_q[wrPtr_q]   <= reqPc_q;
      instMem_q[wrPtr_q] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: behavioural memory with variable latency
// and an expected-PC-stream reference model.
module tb_fetch_queue;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [31:0] out_next_pc;

  fetch_queue #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_next_pc(out_next_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory model: one request in flight, answered after a chosen latency.
  bit          memBusy = 0;
  int          memDelay = 0;
  logic [31:0] memAddr = '0;
  int          latMin = 1;
  int          latMax = 1;
  int          readyMode = 0;

  // Reference model: the next address to be requested and the next PC to retire.
  logic [31:0] expReqPc = RESET_PC;
  logic [31:0] expOutPc = RESET_PC;

  bit          sawFire, sawPop, sawRsp;
  logic [31:0] fireAddr, popPc, popNext;
  int          fireCount = 0;
  int          popCount = 0;

  function automatic logic [31:0] instOf(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  // One clock: drive memory at negedge, sample just before posedge, return after it.
  task automatic cycle();
    @(negedge clk);
    if (rst_n && memBusy && memDelay == 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instOf(memAddr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    case (readyMode)
      0:       imem_req_ready = 1'b1;
      1:       imem_req_ready = 1'b0;
      default: imem_req_ready = ($urandom_range(3, 0) != 0);
    endcase
    #4;
    sawRsp   = imem_rsp_valid;
    sawFire  = imem_req_valid && imem_req_ready;
    sawPop   = out_valid && out_ready && !redirect_valid;
    fireAddr = imem_req_addr;
    popPc    = out_pc;
    popNext  = out_next_pc;
    if (!rst_n) begin
      memBusy  = 0;
      expReqPc = RESET_PC;
      expOutPc = RESET_PC;
    end else begin
      if (imem_rsp_valid) memBusy = 0;
      else if (memBusy) memDelay--;
      if (out_valid === 1'b1) begin
        checks++;
        if (out_pc !== expOutPc || out_inst !== instOf(expOutPc) || out_next_pc !== expOutPc + 32'd4) begin
          errors++;
          $display("[TB] FAIL head: got pc=%h inst=%h next=%h, expected pc=%h inst=%h next=%h",
                   out_pc, out_inst, out_next_pc, expOutPc, instOf(expOutPc), expOutPc + 32'd4);
        end
      end
      if (sawPop) begin
        expOutPc += 32'd4;
        popCount++;
      end
      if (sawFire) begin
        checks++;
        if (memBusy || redirect_valid || fireAddr !== expReqPc) begin
          errors++;
          $display("[TB] FAIL req_addr: got addr=%h busy=%0d redirect=%0d, expected addr=%h with idle memory",
                   fireAddr, memBusy, redirect_valid, expReqPc);
        end
        memBusy  = 1;
        memDelay = $urandom_range(latMax, latMin);
        memAddr  = fireAddr;
        expReqPc += 32'd4;
        fireCount++;
      end
      if (redirect_valid) begin
        expReqPc = {redirect_pc[31:2], 2'b00};
        expOutPc = {redirect_pc[31:2], 2'b00};
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    readyMode = 0;
    repeat (2) cycle();
  endtask

  task automatic test_reset();
    doReset();
    checks++;
    if (imem_req_valid !== 1'b0 || out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0 || out_next_pc !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got req_valid=%b out_valid=%b pc=%h inst=%h next=%h, expected all zero",
               imem_req_valid, out_valid, out_pc, out_inst, out_next_pc);
    end
    rst_n = 1'b1;
    latMin = 1; latMax = 1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (!sawFire || fireAddr !== RESET_PC + 32'(4 * i)) begin
        errors++;
        $display("[TB] FAIL startup_req%0d: got fire=%0d addr=%h, expected fire=1 addr=%h",
                 i, sawFire, fireAddr, RESET_PC + 32'(4 * i));
      end
    end
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (!sawPop || popPc !== 32'h104 + 32'(4 * i)) begin
        errors++;
        $display("[TB] FAIL throughput%0d: got pop=%0d pc=%h, expected pop=1 pc=%h",
                 i, sawPop, popPc, 32'h104 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    doReset();
    rst_n = 1'b1;
    latMin = 1; latMax = 1;
    fireCount = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (i >= 5) begin
        checks++;
        if (sawFire || out_pc !== RESET_PC) begin
          errors++;
          $display("[TB] FAIL full_hold%0d: got fire=%0d head=%h, expected fire=0 head=%h", i, sawFire, out_pc, RESET_PC);
        end
      end
    end
    checks++;
    if (fireCount != DEPTH || imem_req_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_count: got requests=%0d req_valid=%b, expected requests=%0d req_valid=0",
               fireCount, imem_req_valid, DEPTH);
    end
    readyMode = 1;
    out_ready = 1'b1;
    popCount = 0;
    repeat (8) cycle();
    checks++;
    if (popCount != DEPTH || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain: got pops=%0d out_valid=%b, expected pops=%0d out_valid=0", popCount, out_valid, DEPTH);
    end
  endtask

  task automatic test_redirect_inflight();
    bit found;
    doReset();
    rst_n = 1'b1;
    latMin = 3; latMax = 3; out_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (sawFire && fireAddr == 32'h108) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL inflight_setup: got no request for 00000108, expected one within 40 cycles");
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h2002;
    cycle();
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL inflight_flush: got out_valid=%b, expected 0", out_valid);
    end
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      found = sawFire;
    end
    checks++;
    if (!found || fireAddr !== 32'h2000) begin
      errors++;
      $display("[TB] FAIL inflight_next_req: got fire=%0d addr=%h, expected fire=1 addr=00002000", found, fireAddr);
    end
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      found = sawPop;
    end
    checks++;
    if (!found || popPc !== 32'h2000) begin
      errors++;
      $display("[TB] FAIL inflight_next_pop: got pop=%0d pc=%h, expected pop=1 pc=00002000", found, popPc);
    end
  endtask

  task automatic test_redirect_coincident();
    bit found;
    doReset();
    rst_n = 1'b1;
    latMin = 2; latMax = 2; out_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (memBusy && memDelay == 1 && out_valid === 1'b1) found = 1;
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h3000;
    out_ready = 1'b1;
    cycle();
    redirect_valid = 1'b0;
    checks++;
    if (!found || !sawRsp || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL coincident_flush: got setup=%0d rsp=%0d out_valid=%b, expected setup=1 rsp=1 out_valid=0",
               found, sawRsp, out_valid);
    end
    cycle();
    checks++;
    if (!sawFire || fireAddr !== 32'h3000) begin
      errors++;
      $display("[TB] FAIL coincident_resume: got fire=%0d addr=%h, expected fire=1 addr=00003000", sawFire, fireAddr);
    end
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      found = sawPop;
    end
    checks++;
    if (!found || popPc !== 32'h3000) begin
      errors++;
      $display("[TB] FAIL coincident_pop: got pop=%0d pc=%h, expected pop=1 pc=00003000", found, popPc);
    end
  endtask

  task automatic test_stall_random();
    logic [31:0] heldAddr;
    int          popsBefore;
    latMin = 1; latMax = 1; out_ready = 1'b1;
    repeat (3) cycle();
    readyMode = 1;
    cycle();
    heldAddr = imem_req_addr;
    checks++;
    if (heldAddr !== expReqPc) begin
      errors++;
      $display("[TB] FAIL stall_addr: got addr=%h, expected %h", heldAddr, expReqPc);
    end
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (imem_req_addr !== heldAddr) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: got addr=%h, expected %h", i, imem_req_addr, heldAddr);
      end
    end
    readyMode = 2;
    latMin = 1; latMax = 4;
    popsBefore = popCount;
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(3, 0) != 0);
      redirect_valid = ($urandom_range(24, 0) == 0);
      redirect_pc = $urandom;
      cycle();
    end
    redirect_valid = 1'b0;
    checks++;
    if (popCount - popsBefore < 20) begin
      errors++;
      $display("[TB] FAIL random_progress: got %0d pops, expected at least 20", popCount - popsBefore);
    end
  endtask

  task automatic test_wrap();
    bit found;
    readyMode = 0;
    latMin = 1; latMax = 1; out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
        cycle();
        found = sawFire;
      end
      checks++;
      if (!found || fireAddr !== (k == 0 ? 32'hFFFF_FFFC : 32'h0)) begin
        errors++;
        $display("[TB] FAIL wrap_req%0d: got fire=%0d addr=%h, expected fire=1 addr=%h",
                 k, found, fireAddr, (k == 0 ? 32'hFFFF_FFFC : 32'h0));
      end
    end
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      found = sawPop;
    end
    checks++;
    if (!found || popPc !== 32'hFFFF_FFFC || popNext !== 32'h0) begin
      errors++;
      $display("[TB] FAIL wrap_pop: got pop=%0d pc=%h next=%h, expected pop=1 pc=fffffffc next=00000000",
               found, popPc, popNext);
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_coincident();
    test_stall_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
